// File: rtl/dff_rr_write_arbiter_if.sv
// Bus bundle between requester logic, the round-robin write arbiter and the
// shared enabled D register. The arbiter takes the slave side; whoever owns the
// requesters and the register (a testbench, or a wrapper) takes the master side.
interface dff_rr_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [WIDTH-1:0]         reg_q;
  logic                     reg_en;
  logic [WIDTH-1:0]         reg_d;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic                     err;
  logic                     busy;

  modport master (
    output req, lock, wdata, reg_q,
    input  reg_en, reg_d, gnt, ack, err, busy
  );

  modport slave (
    input  req, lock, wdata, reg_q,
    output reg_en, reg_d, gnt, ack, err, busy
  );
endinterface

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin write arbiter for one shared enabled D register.
// Each transaction: IDLE (arbitrate) -> WRITE (en/d driven for one cycle)
// -> CHECK (compare readback q against the held data) -> ack pulse.
// Optional build macro: ARB_LOCK_EN adds a lock owner that keeps re-granting
// the same requester while it holds lock; without it lock is ignored.
module dff_rr_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input logic                   clk,
  input logic                   rst,
  dff_rr_write_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [PW-1:0]      ptr_q,    ptr_d;
  logic [PW-1:0]      sel_q,    sel_d;
  logic [NUM_REQ-1:0] gnt_q,    gnt_d;
  logic [NUM_REQ-1:0] ack_q,    ack_d;
  logic               err_q,    err_d;
  logic               busy_q,   busy_d;
  logic               reg_en_q, reg_en_d;
  logic [WIDTH-1:0]   reg_d_q,  reg_d_d;
  logic [WIDTH-1:0]   hold_q,   hold_d;

  // Round-robin search results
  logic               rr_found;
  logic [PW-1:0]      rr_idx;
  int                 cand;
  logic [PW-1:0]      cand_idx;

  // Final winner after the optional lock override
  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic               use_rr;

`ifdef ARB_LOCK_EN
  logic               owner_vld_q, owner_vld_d;
  logic [PW-1:0]      owner_q,     owner_d;
`else
  logic               unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  // Find the first requester at or above ptr, wrapping; scanning from the far
  // end down lets the closest candidate overwrite the others.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = PW'(cand);
      if (bus.req[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Transaction sequencer: arbitration, write strobe, readback compare, ack.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    reg_en_d = 1'b0;
    reg_d_d  = reg_d_q;
    hold_d   = hold_q;
    win_vld  = rr_found;
    win_idx  = rr_idx;
    use_rr   = 1'b1;
`ifdef ARB_LOCK_EN
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    // A recorded owner wins outright while it still requests; once it lets
    // go of req in IDLE the lock evaporates and plain round-robin resumes.
    if (state_q == ST_IDLE && owner_vld_q) begin
      if (bus.req[owner_q]) begin
        win_vld = 1'b1;
        win_idx = owner_q;
        use_rr  = 1'b0;
      end else begin
        owner_vld_d = 1'b0;
      end
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d        = ST_WRITE;
          sel_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          reg_en_d       = 1'b1;
          reg_d_d        = bus.wdata[win_idx*WIDTH +: WIDTH];
          hold_d         = bus.wdata[win_idx*WIDTH +: WIDTH];
          if (use_rr) begin
            ptr_d = PW'((int'(win_idx) + 1) % NUM_REQ);
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        ack_d   = gnt_q;
        err_d   = (bus.reg_q != hold_q);
        gnt_d   = '0;
`ifdef ARB_LOCK_EN
        owner_vld_d = bus.lock[sel_q];
        owner_d     = sel_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      reg_en_q <= 1'b0;
      reg_d_q  <= '0;
      hold_q   <= '0;
`ifdef ARB_LOCK_EN
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      hold_q   <= hold_d;
`ifdef ARB_LOCK_EN
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign bus.reg_en = reg_en_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;

endmodule
